// File: rtl/pic_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : pic_ctrl_seq
// Purpose  : Wishbone master that initialises the PIC, then polls it for
//            interrupts and serialises runtime mask writes onto the bus.
// Revision : 1.0 - initial release
// ============================================================================
module pic_ctrl_seq #(
    parameter logic [31:0] PIC_BASE  = 32'h0000_0000,
    parameter logic [7:0]  ICW1_VAL  = 8'h11,
    parameter logic [7:0]  ICW2_VAL  = 8'h20,
    parameter logic [7:0]  ICW3_VAL  = 8'h00,
    parameter logic [7:0]  ICW4_VAL  = 8'h01,
    parameter logic [7:0]  INIT_MASK = 8'h00,
    parameter int unsigned HOLDOFF   = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        pic_int_i,
    input  logic        mask_wr_i,
    input  logic [7:0]  mask_i,
    output logic [7:0]  irq_vec_o,
    output logic        irq_valid_o,
    input  logic        irq_ready_i,
    output logic        init_done_o,
    output logic        bus_err_o
);

    localparam logic [3:0] c_st_ini_icw1 = 4'd0;
    localparam logic [3:0] c_st_ini_icw2 = 4'd1;
    localparam logic [3:0] c_st_ini_icw3 = 4'd2;
    localparam logic [3:0] c_st_ini_icw4 = 4'd3;
    localparam logic [3:0] c_st_ini_ocw1 = 4'd4;
    localparam logic [3:0] c_st_idle     = 4'd5;
    localparam logic [3:0] c_st_mask_wr  = 4'd6;
    localparam logic [3:0] c_st_poll_wr  = 4'd7;
    localparam logic [3:0] c_st_poll_rd  = 4'd8;
    localparam logic [3:0] c_st_vec_out  = 4'd9;
    localparam logic [3:0] c_st_hold     = 4'd10;

    localparam logic [3:0] c_sel_cmd  = 4'b0001;
    localparam logic [3:0] c_sel_data = 4'b0010;
    localparam logic [7:0] c_ocw3_poll = 8'h0C;
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_hold_last = 8'(HOLDOFF - 1);

    logic [3:0]  r_state, w_state;
    logic        r_cyc, w_cyc;
    logic        r_we, w_we;
    logic [3:0]  r_sel, w_sel;
    logic [31:0] r_dat, w_dat;
    logic [7:0]  r_wait, w_wait;
    logic [7:0]  r_hold, w_hold;
    logic [7:0]  r_vec, w_vec;
    logic        r_valid, w_valid;
    logic        r_init_done, w_init_done;
    logic        r_bus_err, w_bus_err;
    logic [7:0]  r_mask, w_mask;
    logic        r_mask_pend, w_mask_pend;

    // Per-state transfer descriptor
    logic        w_is_bus;
    logic        w_req_we;
    logic [3:0]  w_req_sel;
    logic [7:0]  w_req_byte;
    logic [3:0]  w_ack_next;
    logic [3:0]  w_to_next;

    logic        w_unused_dat;
    assign w_unused_dat = &{1'b0, dat_i[31:3]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_st_ini_icw1;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'b0000;
            r_dat       <= 32'h0;
            r_wait      <= 8'h0;
            r_hold      <= 8'h0;
            r_vec       <= 8'h0;
            r_valid     <= 1'b0;
            r_init_done <= 1'b0;
            r_bus_err   <= 1'b0;
            r_mask      <= 8'h0;
            r_mask_pend <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cyc       <= w_cyc;
            r_we        <= w_we;
            r_sel       <= w_sel;
            r_dat       <= w_dat;
            r_wait      <= w_wait;
            r_hold      <= w_hold;
            r_vec       <= w_vec;
            r_valid     <= w_valid;
            r_init_done <= w_init_done;
            r_bus_err   <= w_bus_err;
            r_mask      <= w_mask;
            r_mask_pend <= w_mask_pend;
        end
    end

    always_comb begin
        w_is_bus    = 1'b1;
        w_req_we    = 1'b1;
        w_req_sel   = c_sel_data;
        w_req_byte  = 8'h00;
        w_ack_next  = c_st_idle;
        w_to_next   = c_st_ini_icw1;
        w_state     = r_state;
        w_cyc       = r_cyc;
        w_we        = r_we;
        w_sel       = r_sel;
        w_dat       = r_dat;
        w_wait      = r_wait;
        w_hold      = r_hold;
        w_vec       = r_vec;
        w_valid     = r_valid;
        w_init_done = r_init_done;
        w_bus_err   = 1'b0;
        w_mask      = r_mask;
        w_mask_pend = r_mask_pend;

        case (r_state)
            c_st_ini_icw1: begin
                w_req_sel  = c_sel_cmd;
                w_req_byte = ICW1_VAL;
                w_ack_next = c_st_ini_icw2;
            end
            c_st_ini_icw2: begin
                w_req_byte = ICW2_VAL;
                w_ack_next = c_st_ini_icw3;
            end
            c_st_ini_icw3: begin
                w_req_byte = ICW3_VAL;
                w_ack_next = ICW1_VAL[0] ? c_st_ini_icw4 : c_st_ini_ocw1;
            end
            c_st_ini_icw4: begin
                w_req_byte = ICW4_VAL;
                w_ack_next = c_st_ini_ocw1;
            end
            c_st_ini_ocw1: begin
                w_req_byte = INIT_MASK;
            end
            c_st_mask_wr: begin
                w_req_byte = r_mask;
                w_to_next  = c_st_idle;
            end
            c_st_poll_wr: begin
                w_req_sel  = c_sel_cmd;
                w_req_byte = c_ocw3_poll;
                w_ack_next = c_st_poll_rd;
                w_to_next  = c_st_hold;
            end
            c_st_poll_rd: begin
                w_req_we   = 1'b0;
                w_req_sel  = c_sel_cmd;
                w_ack_next = c_st_vec_out;
                w_to_next  = c_st_hold;
            end
            default: w_is_bus = 1'b0;
        endcase

        if (w_is_bus) begin
            if (!r_cyc) begin
                // Launch; the cycle spent here is the inter-transfer gap
                w_cyc  = 1'b1;
                w_we   = w_req_we;
                w_sel  = w_req_sel;
                w_dat  = {4{w_req_byte}};
                w_wait = 8'h0;
            end else if (ack_i) begin
                w_cyc   = 1'b0;
                w_state = w_ack_next;
                if (r_state == c_st_ini_ocw1) w_init_done = 1'b1;
                // A newer mask latched during the transfer must stay pending
                if (r_state == c_st_mask_wr && r_mask == r_dat[7:0]) w_mask_pend = 1'b0;
                if (r_state == c_st_poll_rd) begin
                    w_vec   = {ICW2_VAL[7:3], dat_i[2:0]};
                    w_valid = 1'b1;
                end
            end else if (r_wait == c_wait_last) begin
                w_cyc     = 1'b0;
                w_bus_err = 1'b1;
                w_state   = w_to_next;
                w_hold    = 8'h0;
            end else begin
                w_wait = r_wait + 8'h1;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (r_mask_pend)                   w_state = c_st_mask_wr;
                    else if (r_init_done && pic_int_i) w_state = c_st_poll_wr;
                end
                c_st_vec_out: begin
                    if (r_valid && irq_ready_i) begin
                        w_valid = 1'b0;
                        w_hold  = 8'h0;
                        w_state = c_st_hold;
                    end
                end
                c_st_hold: begin
                    if (r_hold == c_hold_last) w_state = c_st_idle;
                    else                       w_hold  = r_hold + 8'h1;
                end
                default: w_state = c_st_ini_icw1;
            endcase
        end

        if (mask_wr_i) begin
            w_mask_pend = 1'b1;
            w_mask      = mask_i;
        end
    end

    assign cyc_o       = r_cyc;
    assign stb_o       = r_cyc;
    assign we_o        = r_we;
    assign sel_o       = r_sel;
    assign adr_o       = PIC_BASE;
    assign dat_o       = r_dat;
    assign irq_vec_o   = r_vec;
    assign irq_valid_o = r_valid;
    assign init_done_o = r_init_done;
    assign bus_err_o   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_pic_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_ctrl_seq
// Purpose  : Self-checking bench for pic_ctrl_seq with a registered-ack PIC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_ctrl_seq;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
    } txn_t;

    localparam logic [7:0] ICW2 = 8'h20;
    localparam int         HOLD_CYC = 8;
    localparam int         TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc, stb, we, ack = 1'b0;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        pic_int = 1'b0, mask_wr = 1'b0, irq_ready = 1'b0;
    logic [7:0]  mask = 8'h00, irq_vec, poll_byte = 8'h00;
    logic        irq_valid, init_done, bus_err;
    logic        block_icw2 = 1'b0;

    logic        b_rst = 1'b1;
    logic        b_cyc, b_stb, b_we, b_ack = 1'b0;
    logic [3:0]  b_sel;
    logic [31:0] b_adr, b_dat_o;
    logic [7:0]  b_irq_vec;
    logic        b_irq_valid, b_init_done, b_bus_err;

    txn_t q[$];
    txn_t qb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pic_ctrl_seq dut (
        .clk_i(clk), .rst_i(rst), .cyc_o(cyc), .stb_o(stb), .we_o(we), .sel_o(sel),
        .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack), .pic_int_i(pic_int),
        .mask_wr_i(mask_wr), .mask_i(mask), .irq_vec_o(irq_vec), .irq_valid_o(irq_valid),
        .irq_ready_i(irq_ready), .init_done_o(init_done), .bus_err_o(bus_err)
    );

    pic_ctrl_seq #(.ICW1_VAL(8'h10)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .cyc_o(b_cyc), .stb_o(b_stb), .we_o(b_we), .sel_o(b_sel),
        .adr_o(b_adr), .dat_o(b_dat_o), .dat_i(32'h0), .ack_i(b_ack), .pic_int_i(1'b0),
        .mask_wr_i(1'b0), .mask_i(8'h00), .irq_vec_o(b_irq_vec), .irq_valid_o(b_irq_valid),
        .irq_ready_i(1'b0), .init_done_o(b_init_done), .bus_err_o(b_bus_err)
    );

    // PIC slave model: ack registered one cycle after the strobe is seen
    assign dat_i = {24'h0, poll_byte};
    always @(posedge clk) begin
        if (rst) ack <= 1'b0;
        else ack <= cyc && stb && !ack && !(block_icw2 && sel == 4'b0010 && dat_o[7:0] == ICW2);
        if (b_rst) b_ack <= 1'b0;
        else b_ack <= b_cyc && b_stb && !b_ack;
    end

    always @(posedge clk) begin
        if (!rst && cyc && stb && ack) q.push_back({we, sel, dat_o, adr});
        if (!b_rst && b_cyc && b_stb && b_ack) qb.push_back({b_we, b_sel, b_dat_o, b_adr});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected initialisation writes, derived from the ICW bytes
    function automatic txn_t init_txn(input logic [7:0] icw1, input int idx);
        logic [7:0] b[$];
        b = '{icw1, ICW2, 8'h00};
        if (icw1[0]) b.push_back(8'h01);
        b.push_back(8'h00);
        return {1'b1, (idx == 0) ? 4'b0001 : 4'b0010, {4{b[idx]}}, 32'h0};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_checks++;
        if ({cyc, stb, we, irq_valid, init_done, bus_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {cyc, stb, we, irq_valid, init_done, bus_err});
        end
        n_checks++;
        if ({sel, dat_o, irq_vec} !== 44'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {sel, dat_o, irq_vec});
        end
    endtask

    task automatic test_init();
        logic prev = 1'b0;
        int   run = 0, bad = 0, nhi = 0, t = 0;
        q.delete();
        rst = 1'b0;
        while (!init_done && t < 200) begin
            step(); t++;
            if (cyc == prev) run++;
            else begin
                if (prev) begin if (run != 2) bad++; nhi++; end
                else if (nhi > 0 && run != 1) bad++;
                run = 1; prev = cyc;
            end
        end
        n_checks++;
        if (init_done !== 1'b1 || q.size() != 5) begin
            n_fail++; $display("FAIL init_count: got done=%b n=%0d expected done=1 n=5", init_done, q.size());
        end
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            n_checks++;
            if (q[i] !== init_txn(8'h11, i)) begin
                n_fail++; $display("FAIL init_txn%0d: got %h expected %h", i, q[i], init_txn(8'h11, i));
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL init_timing: got %0d bad run lengths expected 0", bad);
        end
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (q.size() != 5 || cyc !== 1'b0) begin
            n_fail++; $display("FAIL idle_quiet: got n=%0d cyc=%b expected n=5 cyc=0", q.size(), cyc);
        end
    endtask

    task automatic test_no_icw4();
        int t = 0;
        qb.delete();
        b_rst = 1'b0;
        while (!b_init_done && t < 200) begin step(); t++; end
        n_checks++;
        if (b_init_done !== 1'b1 || qb.size() != 4) begin
            n_fail++; $display("FAIL noicw4_count: got done=%b n=%0d expected done=1 n=4", b_init_done, qb.size());
        end
        for (int i = 0; i < 4 && i < qb.size(); i++) begin
            n_checks++;
            if (qb[i] !== init_txn(8'h10, i)) begin
                n_fail++; $display("FAIL noicw4_txn%0d: got %h expected %h", i, qb[i], init_txn(8'h10, i));
            end
        end
    endtask

    task automatic test_poll();
        for (int it = 0; it < 6; it++) begin
            logic [2:0] line;
            logic [7:0] exp_vec;
            int t = 0, bad = 0, d;
            line = 3'($urandom_range(0, 7));
            if (it == 0) line = 3'd3;
            exp_vec = {ICW2[7:3], line};
            poll_byte = {1'b1, 4'b0000, line};
            pic_int = 1'b1;
            q.delete();
            while (!irq_valid && t < 100) begin step(); t++; end
            n_checks++;
            if (irq_valid !== 1'b1 || q.size() != 2) begin
                n_fail++; $display("FAIL poll_seq%0d: got valid=%b n=%0d expected valid=1 n=2", it, irq_valid, q.size());
            end
            if (q.size() == 2) begin
                n_checks++;
                if (q[0] !== {1'b1, 4'b0001, 32'h0C0C0C0C, 32'h0} || {q[1].we, q[1].sel, q[1].adr} !== {1'b0, 4'b0001, 32'h0}) begin
                    n_fail++; $display("FAIL poll_txn%0d: got %h %h expected write 0C sel1 then read sel1", it, q[0], q[1]);
                end
            end
            n_checks++;
            if (irq_vec !== exp_vec) begin
                n_fail++; $display("FAIL poll_vec%0d: got %h expected %h", it, irq_vec, exp_vec);
            end
            d = $urandom_range(0, 4);
            for (int i = 0; i < d; i++) begin
                step();
                if (!irq_valid || irq_vec !== exp_vec || cyc) bad++;
            end
            irq_ready = 1'b1;
            step();
            irq_ready = 1'b0;
            if (it == 5) pic_int = 1'b0;
            n_checks++;
            if (irq_valid !== 1'b0 || bad != 0) begin
                n_fail++; $display("FAIL poll_handshake%0d: got valid=%b stall_err=%0d expected valid=0 stall_err=0", it, irq_valid, bad);
            end
            bad = 0;
            for (int i = 0; i < HOLD_CYC; i++) begin step(); if (cyc) bad++; end
            n_checks++;
            if (bad != 0) begin
                n_fail++; $display("FAIL poll_holdoff%0d: got %0d busy cycles expected 0", it, bad);
            end
        end
    endtask

    task automatic test_mask_defer();
        int t = 0, bad = 0;
        logic [7:0] exp_vec;
        logic [2:0] line;
        line = 3'($urandom_range(0, 7));
        exp_vec = {ICW2[7:3], line};
        poll_byte = {1'b1, 4'b0000, line};
        pic_int = 1'b1;
        while (!irq_valid && t < 100) begin step(); t++; end
        for (int i = 0; i < 20; i++) begin
            mask_wr = (i == 3);
            mask = 8'hF0;
            step();
            if (!irq_valid || irq_vec !== exp_vec || cyc) bad++;
        end
        mask_wr = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL defer_stable: got %0d unstable cycles expected 0", bad);
        end
        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        q.delete();
        t = 0;
        while (!irq_valid && t < 100) begin step(); t++; end
        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        pic_int = 1'b0;
        n_checks++;
        if (q.size() < 2 || q[0] !== {1'b1, 4'b0010, 32'hF0F0F0F0, 32'h0} || q[1] !== {1'b1, 4'b0001, 32'h0C0C0C0C, 32'h0}) begin
            n_fail++; $display("FAIL defer_order: got n=%0d first=%h expected mask F0 write before poll", q.size(), (q.size() > 0) ? q[0] : txn_t'(0));
        end
        for (int i = 0; i < HOLD_CYC + 4; i++) step();
    endtask

    task automatic test_mask_last_wins();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] a, b;
            int gap, bad = 0;
            a = 8'($urandom);
            b = 8'($urandom);
            gap = $urandom_range(0, 5);
            q.delete();
            mask_wr = 1'b1; mask = a; step();
            mask_wr = 1'b0;
            for (int i = 0; i < gap; i++) step();
            mask_wr = 1'b1; mask = b; step();
            mask_wr = 1'b0;
            for (int i = 0; i < 30; i++) step();
            foreach (q[i]) if (q[i].we !== 1'b1 || q[i].sel !== 4'b0010) bad++;
            n_checks++;
            if (q.size() == 0 || q[q.size() - 1].dat !== {4{b}} || bad != 0) begin
                n_fail++; $display("FAIL mask_last%0d: got n=%0d last=%h expected last data %h", k, q.size(), (q.size() > 0) ? q[q.size() - 1].dat : 32'h0, {4{b}});
            end
        end
    endtask

    task automatic test_timeout();
        int t = 0, n = 0;
        rst = 1'b1;
        step();
        block_icw2 = 1'b1;
        rst = 1'b0;
        while (!(cyc && dat_o == {4{ICW2}}) && t < 50) begin step(); t++; end
        while (cyc && n < 100) begin n++; step(); end
        n_checks++;
        if (n != TO_CYC || bus_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_len: got %0d cycles err=%b expected %0d cycles err=1", n, bus_err, TO_CYC);
        end
        block_icw2 = 1'b0;
        step();
        n_checks++;
        if (bus_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pulse: got err=%b expected 0", bus_err);
        end
        t = 0;
        while (!cyc && t < 10) begin step(); t++; end
        n_checks++;
        if ({cyc, we, sel, dat_o} !== {1'b1, 1'b1, 4'b0001, 32'h11111111}) begin
            n_fail++; $display("FAIL timeout_restart: got %h expected ICW1 write", {cyc, we, sel, dat_o});
        end
        t = 0;
        while (!init_done && t < 100) begin step(); t++; end
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++; $display("FAIL timeout_reinit: got done=%b expected 1", init_done);
        end
    endtask

    task automatic test_reset_mid_poll();
        int t = 0;
        poll_byte = 8'h85;
        pic_int = 1'b1;
        while (!(cyc && !we) && t < 100) begin step(); t++; end
        rst = 1'b1;
        step();
        n_checks++;
        if ({cyc, irq_valid, init_done} !== 3'b000 || t >= 100) begin
            n_fail++; $display("FAIL rst_mid: got cyc=%b valid=%b done=%b expected 000", cyc, irq_valid, init_done);
        end
        pic_int = 1'b0;
        rst = 1'b0;
        q.delete();
        t = 0;
        while (!init_done && t < 100) begin step(); t++; end
        n_checks++;
        if (init_done !== 1'b1 || q.size() != 5 || q[0] !== init_txn(8'h11, 0)) begin
            n_fail++; $display("FAIL rst_reinit: got done=%b n=%0d expected done=1 n=5 ICW1 first", init_done, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_no_icw4();
        test_poll();
        test_mask_defer();
        test_mask_last_wins();
        test_timeout();
        test_reset_mid_poll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
